// File: rtl/special_functions_seq_if.sv
// Handshake bundle between the SP-class issue stage and the sequential special-function unit.
// master drives operands and accepts results; slave is the functional unit.
interface special_functions_seq_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/special_functions_seq.sv
// Sequential special-function unit: SP1..SP5 using a radix-2 shift-add multiplier,
// one operation in flight, valid/ready on both sides.
module special_functions_seq #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SP2_SHIFT = 2
) (
    input logic                  clk,
    input logic                  rst,
    special_functions_seq_if.slave sf_io
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [3:0] OpSp1 = 4'd1;
    localparam logic [3:0] OpSp2 = 4'd2;
    localparam logic [3:0] OpSp3 = 4'd3;
    localparam logic [3:0] OpSp4 = 4'd4;
    localparam logic [3:0] OpSp5 = 4'd5;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] prod_sum;
    logic [WIDTH-1:0] func_res;
    logic             is_mul_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            prod_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // The final partial product is folded in combinationally so the result lands on the last MUL edge.
    always_comb begin
        term     = b_q[cnt_q] ? (a_q << cnt_q) : '0;
        prod_sum = prod_q + term;
        case (op_q)
            OpSp1:   func_res = prod_sum - a_q;
            OpSp2:   func_res = (prod_sum << SP2_SHIFT) - a_q;
            OpSp3:   func_res = prod_sum + a_q;
            OpSp5:   func_res = prod_sum + b_q;
            default: func_res = '0;
        endcase
    end

    assign is_mul_op = (sf_io.op == OpSp1) || (sf_io.op == OpSp2) ||
                       (sf_io.op == OpSp3) || (sf_io.op == OpSp5);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (sf_io.in_valid) begin
                    a_d  = sf_io.a;
                    b_d  = sf_io.b;
                    op_d = sf_io.op;
                    if (is_mul_op) begin
                        cnt_d   = '0;
                        prod_d  = '0;
                        state_d = StMul;
                    end else begin
                        result_d = (sf_io.op == OpSp4) ? ((sf_io.a << 1) + sf_io.a) : '0;
                        err_d    = (sf_io.op != OpSp4);
                        state_d  = StDone;
                    end
                end
            end
            StMul: begin
                prod_d = prod_sum;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    result_d = func_res;
                    err_d    = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (sf_io.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sf_io.in_ready  = (state_q == StIdle);
    assign sf_io.out_valid = (state_q == StDone);
    assign sf_io.result    = result_q;
    assign sf_io.err       = err_q;
endmodule

// File: tb/tb_special_functions_seq.sv
// Scoreboard bench for special_functions_seq: expectations queued at issue, checked at output.
module tb_special_functions_seq;
    localparam int unsigned W = 32;
    localparam int unsigned S = 2;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    special_functions_seq_if #(.WIDTH(W)) sf_if ();

    special_functions_seq #(.WIDTH(W), .SP2_SHIFT(S)) dut (
        .clk   (clk),
        .rst   (rst),
        .sf_io (sf_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic e, output int lat);
        logic [W-1:0] p;
        p   = a * b;
        e   = 1'b0;
        lat = W;
        case (op)
            4'd1: r = p - a;
            4'd2: r = (p << S) - a;
            4'd3: r = p + a;
            4'd4: begin r = (a << 1) + a; lat = 1; end
            4'd5: r = p + b;
            default: begin r = '0; e = 1'b1; lat = 1; end
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push);
        exp_t e;
        bit   ok;
        bit   rdy;
        ok = 1'b0;
        @(negedge clk);
        sf_if.op = op;
        sf_if.a = a;
        sf_if.b = b;
        sf_if.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rdy = (sf_if.in_ready === 1'b1);
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        sf_if.in_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept: op=%0d never accepted (in_ready=%b), required acceptance", op,
                     sf_if.in_ready);
        end
        if (push) begin
            model(op, a, b, e.res, e.err, e.lat);
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic collect(input string name);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sf_if.out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || sb.size() == 0) begin
            bad++;
            $display("FAIL %s out_valid: seen=%b queued=%0d, required a result", name, seen,
                     sb.size());
            if (sb.size() > 0) e = sb.pop_front();
            return;
        end
        e = sb.pop_front();
        total += 3;
        if (sf_if.result !== e.res) begin
            bad++;
            $display("FAIL %s result: got %h expected %h", name, sf_if.result, e.res);
        end
        if (sf_if.err !== e.err) begin
            bad++;
            $display("FAIL %s err: got %b expected %b", name, sf_if.err, e.err);
        end
        if (cyc - e.acc !== e.lat) begin
            bad++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc - e.acc, e.lat);
        end
        sf_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        sf_if.out_ready = 1'b0;
        total += 2;
        if (sf_if.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s release out_valid: got %b expected 0", name, sf_if.out_valid);
        end
        if (sf_if.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s release in_ready: got %b expected 1", name, sf_if.in_ready);
        end
    endtask

    task automatic test_reset();
        total += 4;
        if (sf_if.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset in_ready: got %b expected 1", sf_if.in_ready);
        end
        if (sf_if.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset out_valid: got %b expected 0", sf_if.out_valid);
        end
        if (sf_if.result !== '0) begin
            bad++;
            $display("FAIL reset result: got %h expected 0", sf_if.result);
        end
        if (sf_if.err !== 1'b0) begin
            bad++;
            $display("FAIL reset err: got %b expected 0", sf_if.err);
        end
    endtask

    task automatic test_mul_ops();
        issue(4'd1, 32'd5, 32'd7, 1'b1);
        collect("sp1");
        issue(4'd2, 32'd3, 32'd4, 1'b1);
        collect("sp2");
        issue(4'd5, 32'd6, 32'd9, 1'b1);
        collect("sp5");
        issue(4'd3, 32'hFFFF_FFFF, 32'd2, 1'b1);
        collect("sp3_wrap");
        issue(4'd1, 32'd9, 32'd0, 1'b1);
        collect("sp1_b0");
    endtask

    task automatic test_short_ops();
        issue(4'd4, 32'h7FFF_FFFF, 32'd0, 1'b1);
        collect("sp4");
        issue(4'd0, 32'd1, 32'd1, 1'b1);
        collect("unsup0");
        issue(4'd15, 32'd1, 32'd1, 1'b1);
        collect("unsup15");
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   seen;
        issue(4'd5, 32'd6, 32'd9, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sf_if.out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL bp out_valid: got 0 expected 1");
        end
        // A pending SP4 must not sneak in while the result is held.
        sf_if.op = 4'd4;
        sf_if.a = 32'd1;
        sf_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total += 3;
            if (sf_if.result !== e.res) begin
                bad++;
                $display("FAIL bp hold result: got %h expected %h", sf_if.result, e.res);
            end
            if (sf_if.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp hold in_ready: got %b expected 0", sf_if.in_ready);
            end
            if (sf_if.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp hold out_valid: got %b expected 1", sf_if.out_valid);
            end
        end
        @(negedge clk);
        sf_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        sf_if.out_ready = 1'b0;
        sf_if.in_valid = 1'b0;
        total += 2;
        if (sf_if.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp release in_ready: got %b expected 1", sf_if.in_ready);
        end
        if (sf_if.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp release out_valid: got %b expected 0", sf_if.out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (sf_if.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL bp no_accept out_valid: got %b expected 0", sf_if.out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        issue(4'd1, 32'd5, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total += 3;
        if (sf_if.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid out_valid: got %b expected 0", sf_if.out_valid);
        end
        if (sf_if.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid in_ready: got %b expected 1", sf_if.in_ready);
        end
        if (sf_if.result !== '0) begin
            bad++;
            $display("FAIL rst_mid result: got %h expected 0", sf_if.result);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(4'd3, 32'd2, 32'd3, 1'b1);
        collect("sp3_after_rst");
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops[8];
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd7, 4'd15};
        for (int i = 0; i < 8; i++) begin
            issue(ops[$urandom_range(7, 0)], $urandom, $urandom, 1'b1);
            collect("b2b");
        end
    endtask

    initial begin
        rst = 1'b1;
        sf_if.in_valid = 1'b0;
        sf_if.out_ready = 1'b0;
        sf_if.op = '0;
        sf_if.a = '0;
        sf_if.b = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_mul_ops();
        test_short_ops();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
